// File: rtl/bresenham_pkg.sv
// Shared types for the Bresenham ray stepper.
//   coord_t  : signed ray offsets and emitted first-octant coordinates
//   err_t    : signed Bresenham error accumulator (two bits of headroom)
//   state_t  : stepper FSM states
//   octant_t : flags that let the flip stage map points back to real offsets
package bresenham_pkg;

    localparam int COORD_W = 10;
    localparam int ERR_W   = COORD_W + 2;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [ERR_W-1:0]   err_t;

    typedef enum logic [1:0] {IDLE, SETUP, EMIT} state_t;

    typedef struct packed {
        logic flip_x;
        logic flip_y;
        logic flip_identity;
    } octant_t;

    // Sign-extend a coordinate into the error accumulator width.
    function automatic err_t to_err(coord_t v);
        return err_t'(v);
    endfunction

endpackage

// File: rtl/bresenham_stepper_if.sv
// Ray request / point response handshake bundle.
//   master : upstream ray source plus downstream point consumer
//   slave  : the stepper
interface bresenham_stepper_if;
    import bresenham_pkg::*;

    logic   ray_valid;
    logic   ray_ready;
    coord_t dx_in;
    coord_t dy_in;

    logic   pt_valid;
    logic   pt_ready;
    coord_t x_out;
    coord_t y_out;
    logic   flip_x;
    logic   flip_y;
    logic   flip_identity;
    logic   pt_last;

    modport master (
        output ray_valid, dx_in, dy_in, pt_ready,
        input  ray_ready, pt_valid, x_out, y_out,
               flip_x, flip_y, flip_identity, pt_last
    );

    modport slave (
        input  ray_valid, dx_in, dy_in, pt_ready,
        output ray_ready, pt_valid, x_out, y_out,
               flip_x, flip_y, flip_identity, pt_last
    );

endinterface

// File: rtl/bresenham_stepper_octant_normalize.sv
// Folds a signed (dx, dy) offset into the first octant.
//   dx, dy : signed ray endpoint offset (-2^(COORD_W-1) excluded)
//   a      : major length max(|dx|, |dy|)
//   b      : minor length min(|dx|, |dy|)
//   oct    : flags needed to undo the fold
module octant_normalize
    import bresenham_pkg::*;
(
    input  coord_t  dx,
    input  coord_t  dy,
    output coord_t  a,
    output coord_t  b,
    output octant_t oct
);

    coord_t ax;
    coord_t ay;
    logic   swap;

    always_comb begin
        ax   = dx[COORD_W-1] ? -dx : dx;
        ay   = dy[COORD_W-1] ? -dy : dy;
        swap = (ay > ax);

        a = swap ? ay : ax;
        b = swap ? ax : ay;

        // When axes are swapped, x_out walks the real y axis, so the sign
        // that belongs to x_out is dy's.
        oct.flip_identity = swap;
        oct.flip_x        = swap ? dy[COORD_W-1] : dx[COORD_W-1];
        oct.flip_y        = swap ? dx[COORD_W-1] : dy[COORD_W-1];
    end

endmodule

// File: rtl/bresenham_stepper.sv
// Bresenham line stepper: accepts one ray offset, normalises it to the first
// octant and emits one (major, minor) cell per point handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ray request in (valid/ready, dx_in/dy_in), point out
//                (valid/ready, x_out/y_out, octant flags, pt_last)
module bresenham_stepper
    import bresenham_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    bresenham_stepper_if.slave        bus
);

    state_t  state, state_nx;

    coord_t  dx_q, dy_q;
    coord_t  a_q, b_q;
    coord_t  a_n, b_n;
    coord_t  x_q, y_q;
    err_t    err_q;
    octant_t oct_q, oct_n;
    logic    last_q;

    logic    ray_fire;
    logic    pt_fire;

    assign ray_fire = bus.ray_valid && bus.ray_ready;
    assign pt_fire  = bus.pt_valid && bus.pt_ready;

    // Normalise the latched offset; consumed only in SETUP.
    octant_normalize u_norm (
        .dx  (dx_q),
        .dy  (dy_q),
        .a   (a_n),
        .b   (b_n),
        .oct (oct_n)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ray_fire) state_nx = SETUP;
            SETUP:   state_nx = EMIT;
            EMIT:    if (pt_fire && last_q) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs; decoded from state so reset clears them asynchronously.
    always_comb begin
        bus.ray_ready = (state == IDLE);
        bus.pt_valid  = (state == EMIT);
    end

    // Datapath: latched ray, octant, walk counters and error accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx_q   <= '0;
            dy_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            err_q  <= '0;
            oct_q  <= '0;
            last_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ray_fire) begin
                        dx_q <= bus.dx_in;
                        dy_q <= bus.dy_in;
                    end
                end
                SETUP: begin
                    a_q    <= a_n;
                    b_q    <= b_n;
                    oct_q  <= oct_n;
                    x_q    <= '0;
                    y_q    <= '0;
                    err_q  <= (to_err(b_n) <<< 1) - to_err(a_n);
                    last_q <= (a_n == '0);
                end
                EMIT: begin
                    if (pt_fire && !last_q) begin
                        x_q <= x_q + coord_t'(1);
                        if (err_q > err_t'(0)) begin
                            y_q   <= y_q + coord_t'(1);
                            err_q <= err_q + ((to_err(b_q) - to_err(a_q)) <<< 1);
                        end else begin
                            err_q <= err_q + (to_err(b_q) <<< 1);
                        end
                        last_q <= ((x_q + coord_t'(1)) == a_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.x_out         = x_q;
    assign bus.y_out         = y_q;
    assign bus.flip_x        = oct_q.flip_x;
    assign bus.flip_y        = oct_q.flip_y;
    assign bus.flip_identity = oct_q.flip_identity;
    assign bus.pt_last       = last_q;

endmodule
